// File: rtl/logic_unit_scheduler_pkg.sv
// Shared definitions for the logic unit scheduler: the opcode map of the
// shared bitwise unit and the scheduler FSM state encoding.
package logic_unit_scheduler_pkg;

  // Opcode map of the shared logic unit, {s2,s1,s0}
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational 8-function bitwise logic unit shared by all requesters.
// Operand b is ignored for OP_NOT and OP_BUF.
module logic_unit_core
  import logic_unit_scheduler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Function select driven by the 3-bit opcode
  always_comb begin
    // NOTE: default assignment first so no path leaves y unassigned (no latch).
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one bitwise logic unit among NUM_REQ
// requesters. One transaction is in flight at a time: IDLE grants, EXEC
// computes and registers the result, RESP holds it until accepted.
// Optional macro LOGIC_SCHED_PARITY_EN adds a registered even-parity output
// rsp_parity alongside rsp_data.
module logic_unit_scheduler
  import logic_unit_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
`ifdef LOGIC_SCHED_PARITY_EN
  ,
  output logic                     rsp_parity
`endif
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [2:0]        lat_op;
  logic [WIDTH-1:0]  lat_a;
  logic [WIDTH-1:0]  lat_b;
  logic [ID_W-1:0]   lat_id;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   rr_next;
  logic [WIDTH-1:0]  core_y;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_next = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
  end

  // Accept strobe: one-hot to the winner, only while IDLE
  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op (lat_op),
    .a  (lat_a),
    .b  (lat_b),
    .y  (core_y)
  );

  // Scheduler FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched operands are reset along with the visible outputs;
      // they are few flops and keeping them deterministic costs nothing.
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      lat_op    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef LOGIC_SCHED_PARITY_EN
      rsp_parity <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            lat_op <= req_op[3*int'(grant_idx) +: 3];
            lat_a  <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
            lat_b  <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
            lat_id <= grant_idx;
            rr_ptr <= rr_next;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= core_y;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
`ifdef LOGIC_SCHED_PARITY_EN
          rsp_parity <= ^core_y;
`endif
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Self-checking bench for logic_unit_scheduler (NUM_REQ=4, WIDTH=8).
// Directed scenarios followed by a randomized run against a reference model.
module tb_logic_unit_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
`ifdef LOGIC_SCHED_PARITY_EN
  logic                     rsp_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic_unit_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef LOGIC_SCHED_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference meaning of each opcode
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]             = 1'b1;
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
      next_cycle();
    end
  endtask

  task automatic test_single();
    set_req(1, 3'd2, 8'hF0, 8'h3C);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    next_cycle();
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_exec: got %b expected 0000", req_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_exec: got %b expected 1", busy); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b expected 0", rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'hCC) begin n_err++; $display("FAIL single_data: got %h expected cc", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL single_id: got %0d expected 1", rsp_id); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_done: got %b expected 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b expected 0", busy); end
    next_cycle();
  endtask

  task automatic test_all_four();
    logic [WIDTH-1:0] exp_d [4];
    exp_d = '{8'h0A, 8'hAF, 8'hF5, 8'h55};
    do_reset();
    set_req(0, 3'd0, 8'hAA, 8'h0F);
    set_req(1, 3'd1, 8'hAA, 8'h0F);
    set_req(2, 3'd4, 8'hAA, 8'h0F);
    set_req(3, 3'd6, 8'hAA, 8'h0F);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'(1 << k)) begin n_err++; $display("FAIL all4_grant_%0d: got %b expected %b", k, req_ready, 4'(1 << k)); end
      next_cycle();
      req_valid[k] = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL all4_ready_exec_%0d: got %b expected 0000", k, req_ready); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL all4_valid_%0d: got %b expected 1", k, rsp_valid); end
      n_cmp++; if (rsp_data !== exp_d[k]) begin n_err++; $display("FAIL all4_data_%0d: got %h expected %h", k, rsp_data, exp_d[k]); end
      n_cmp++; if (rsp_id !== 2'(k)) begin n_err++; $display("FAIL all4_id_%0d: got %0d expected %0d", k, rsp_id, k); end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 0 here; requester 2 alone is granted
    set_req(2, 3'd5, 8'h00, 8'h01);
    rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid[2] = 1'b0;
    set_req(1, 3'd7, 8'h3C, 8'h00);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_exec: got %b expected 0000", req_ready); end
    next_cycle();
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold: got %b expected 1", rsp_valid); end
      n_cmp++; if (rsp_data !== 8'hFE) begin n_err++; $display("FAIL bp_data_hold: got %h expected fe", rsp_data); end
      n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL bp_id_hold: got %0d expected 2", rsp_id); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_hold: got %b expected 0000", req_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy_hold: got %b expected 1", busy); end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_release: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 8'hFE) begin n_err++; $display("FAIL bp_data_release: got %h expected fe", rsp_data); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_after: got %b expected 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_waiting_grant: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid[1] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h3C) begin n_err++; $display("FAIL bp_waiting_data: got %h expected 3c", rsp_data); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_waiting_id: got %0d expected 1", rsp_id); end
    next_cycle();
  endtask

  task automatic test_fairness_wrap();
    // rr_ptr is 2 here; serving requester 2 moves it to 3
    set_req(2, 3'd3, 8'hFF, 8'h0F);
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_pre_grant: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid[2] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h0F) begin n_err++; $display("FAIL wrap_pre_data: got %h expected 0f", rsp_data); end
    next_cycle();
    set_req(3, 3'd0, 8'hFF, 8'h33);
    set_req(0, 3'd1, 8'h10, 8'h01);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b expected 1000", req_ready); end
    next_cycle();
    req_valid[3] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h33 || rsp_id !== 2'd3) begin n_err++; $display("FAIL wrap_first_rsp: got %h/%0d expected 33/3", rsp_data, rsp_id); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_second: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid[0] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h11 || rsp_id !== 2'd0) begin n_err++; $display("FAIL wrap_second_rsp: got %h/%0d expected 11/0", rsp_data, rsp_id); end
    next_cycle();
    // rr_ptr should now be 1: requester 1 beats 0 and 3
    set_req(0, 3'd0, 8'h00, 8'h00);
    set_req(1, 3'd6, 8'h0F, 8'h00);
    set_req(3, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_ptr_one: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'hF0 || rsp_id !== 2'd1) begin n_err++; $display("FAIL wrap_ptr_rsp: got %h/%0d expected f0/1", rsp_data, rsp_id); end
    next_cycle();
  endtask

  task automatic test_reset_mid_resp();
    // rr_ptr is 2 here; requester 0 served, leaving rr_ptr at 1 before reset
    set_req(0, 3'd7, 8'h5A, 8'h00);
    rsp_ready = 1'b0;
    next_cycle();
    req_valid[0] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b expected 1", rsp_valid); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin n_err++; $display("FAIL midrst_data: got %h/%0d expected 00/0", rsp_data, rsp_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
    next_cycle();
    // rr_ptr back at 0: requester 0 wins over 1
    set_req(0, 3'd7, 8'h07, 8'h00);
    set_req(1, 3'd4, 8'hFF, 8'hFF);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_new_grant: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid[0] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h07 || rsp_id !== 2'd0) begin n_err++; $display("FAIL midrst_new_rsp: got %h/%0d expected 07/0", rsp_data, rsp_id); end
`ifdef LOGIC_SCHED_PARITY_EN
    n_cmp++; if (rsp_parity !== 1'b1) begin n_err++; $display("FAIL midrst_parity: got %b expected 1", rsp_parity); end
`endif
    next_cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_second_grant: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid[1] = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_data !== 8'h00 || rsp_id !== 2'd1) begin n_err++; $display("FAIL midrst_second_rsp: got %h/%0d expected 00/1", rsp_data, rsp_id); end
`ifdef LOGIC_SCHED_PARITY_EN
    n_cmp++; if (rsp_parity !== 1'b0) begin n_err++; $display("FAIL midrst_second_parity: got %b expected 0", rsp_parity); end
`endif
    next_cycle();
  endtask

  // Random traffic: model tracks the fairness pointer, whether a transaction
  // is outstanding, and when its result must be visible
  task automatic test_random();
    int               mdl_ptr;
    bit               outstanding;
    int               grant_step;
    int               drop;
    int               w;
    logic [3:0]       exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic [ID_W-1:0]  exp_id;
    do_reset();
    mdl_ptr = 0;
    outstanding = 1'b0;
    grant_step = 0;
    drop = -1;
    exp_data = '0;
    exp_id = '0;
    for (int s = 0; s < 400; s++) begin
      if (drop >= 0) req_valid[drop] = 1'b0;
      drop = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0)
            set_req(i, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
        end else if ($urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      exp_ready = '0;
      w = -1;
      if (!outstanding) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int c;
          c = (mdl_ptr + k) % NUM_REQ;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready step %0d: got %b expected %b", s, req_ready, exp_ready); end
      n_cmp++; if (busy !== outstanding) begin n_err++; $display("FAIL rnd_busy step %0d: got %b expected %b", s, busy, outstanding); end
      if (outstanding && (s - grant_step) >= 2) begin
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid step %0d: got %b expected 1", s, rsp_valid); end
        n_cmp++; if (rsp_data !== exp_data) begin n_err++; $display("FAIL rnd_data step %0d: got %h expected %h", s, rsp_data, exp_data); end
        n_cmp++; if (rsp_id !== exp_id) begin n_err++; $display("FAIL rnd_id step %0d: got %0d expected %0d", s, rsp_id, exp_id); end
`ifdef LOGIC_SCHED_PARITY_EN
        n_cmp++; if (rsp_parity !== ^exp_data) begin n_err++; $display("FAIL rnd_parity step %0d: got %b expected %b", s, rsp_parity, ^exp_data); end
`endif
      end else begin
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd_valid_low step %0d: got %b expected 0", s, rsp_valid); end
      end
      if (w >= 0) begin
        exp_data    = ref_op(req_op[3*w +: 3], req_a[WIDTH*w +: WIDTH], req_b[WIDTH*w +: WIDTH]);
        exp_id      = ID_W'(w);
        outstanding = 1'b1;
        grant_step  = s;
        mdl_ptr     = (w + 1) % NUM_REQ;
        drop        = w;
      end else if (outstanding && (s - grant_step) >= 2 && rsp_ready) begin
        outstanding = 1'b0;
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness_wrap();
    test_reset_mid_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
